// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared definitions for the multiplexed seven-segment driver.
//   SEG_BLANK    - all segments off (outputs are active-low)
//   HEX7_TABLE   - active-low segment patterns for nibbles 0..F, bit 0 = a .. bit 6 = g
//   scan_state_e - scan FSM states: GAP (anti-ghost blank) and SHOW (digit lit)
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element 0 is the leftmost entry, so the table reads in nibble order.
    localparam logic [0:15][6:0] HEX7_TABLE = {
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex7_decode.sv
// hex7_decode: combinational hex nibble to active-low seven-segment pattern.
//   nib - 4-bit hex value
//   seg - segments a..g on bits 0..6, active-low
module hex7_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[nib];

endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed driver for NUM_DIGITS common-anode style
// seven-segment digits.
//
// Each digit owns a slot of SLOT_CYCLES clocks: the first GAP_CYCLES are blank
// (anti-ghosting), the rest light the digit. New data is taken through a
// one-deep pending register and only moved to the display register at the
// frame boundary (wrap from the last digit to digit 0), so a frame never mixes
// old and new data.
//
// Optional build macro SEVEN_SEG_LZB_EN: leading-zero blanking. Digits above
// the most significant nonzero nibble show blank segments; digit 0 and digits
// with a lit decimal point are never blanked.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active-low
//   value  - NUM_DIGITS hex nibbles, nibble i drives digit i (digit 0 = LSD)
//   dp_in  - decimal point request per digit (1 = lit)
//   load   - capture request for value/dp_in, accepted when ready=1
//   ready  - high when a load will be accepted
//   seg    - segments a..g on bits 0..6, active-low, registered
//   dp     - decimal point segment, active-low, registered
//   an     - digit enables, active-low, registered
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    ready,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] disp_nib;
    logic [NUM_DIGITS-1:0][3:0] pend_nib;
    logic [NUM_DIGITS-1:0]      disp_dp;
    logic [NUM_DIGITS-1:0]      pend_dp;

    scan_state_e   state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    logic [6:0] dec_seg;
    logic [6:0] show_seg;
    logic       frame_end;

    hex7_decode u_dec (
        .nib (disp_nib[idx]),
        .seg (dec_seg)
    );

`ifdef SEVEN_SEG_LZB_EN
    // Index of the most significant nonzero nibble; 0 when all are zero.
    logic [IW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++)
            if (disp_nib[i] != 4'h0)
                msd = IW'(i);
    end

    // idx > msd already excludes digit 0.
    assign show_seg = (idx > msd && !disp_dp[idx]) ? SEG_BLANK : dec_seg;
`else
    assign show_seg = dec_seg;
`endif

    // Last SHOW cycle of the last digit: the next edge starts a new frame.
    assign frame_end = (state == SHOW) && (cnt == SLOT_LAST) && (idx == IDX_LAST);

    // Scan FSM. Outputs are loaded on the edge that enters a state, so seg, dp
    // and an always switch together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= GAP;
            cnt   <= '0;
            idx   <= '0;
            seg   <= SEG_BLANK;
            dp    <= 1'b1;
            an    <= '1;
        end else begin
            case (state)
                GAP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == GAP_LAST) begin
                        state <= SHOW;
                        seg   <= show_seg;
                        dp    <= ~disp_dp[idx];
                        an    <= ~(NUM_DIGITS'(1) << idx);
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt   <= '0;
                        state <= GAP;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                        seg   <= SEG_BLANK;
                        dp    <= 1'b1;
                        an    <= '1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= GAP;
            endcase
        end
    end

    // Load path. ready doubles as "pending register empty", so a transfer and
    // a new capture can never collide: a load on the boundary cycle is only
    // accepted when nothing is pending, and then waits a full frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_nib <= '0;
            disp_dp  <= '0;
            pend_nib <= '0;
            pend_dp  <= '0;
            ready    <= 1'b1;
        end else if (frame_end && !ready) begin
            disp_nib <= pend_nib;
            disp_dp  <= pend_dp;
            ready    <= 1'b1;
        end else if (load && ready) begin
            pend_nib <= value;
            pend_dp  <= dp_in;
            ready    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed bench for seven_seg_mux with NUM_DIGITS=4,
// SLOT_CYCLES=8, GAP_CYCLES=2. Expected slot contents are queued per frame and
// popped as the scan reaches each slot; loads are scheduled at (slot, cycle).
module tb_seven_seg_mux;

    localparam int ND   = 4;
    localparam int SLOT = 8;
    localparam int GAPC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   value = '0;
    logic [ND-1:0] dp_in = '0;
    logic          load = 1'b0;
    logic          ready;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;

    seven_seg_mux #(.NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .GAP_CYCLES(GAPC)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .dp_in (dp_in),
        .load  (load),
        .ready (ready),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } exp_t;

    typedef struct {
        int          slot;
        int          cyc;
        logic [15:0] v;
        logic [3:0]  d;
        logic        rdy;
    } ev_t;

    exp_t sb[$];
    ev_t  ev_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Queue the four slots of one frame showing v/d; rdy is ready during SHOW.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input logic rdy);
        int   msd;
        exp_t e;
        msd = 0;
        for (int i = 1; i < ND; i++)
            if (v[i*4 +: 4] != 4'h0) msd = i;
        for (int i = 0; i < ND; i++) begin
            e.an  = ~(4'b0001 << i);
            e.seg = ref_seg(v[i*4 +: 4]);
`ifdef SEVEN_SEG_LZB_EN
            if (i > msd && !d[i]) e.seg = 7'h7F;
`endif
            e.dp  = ~d[i];
            e.rdy = rdy;
            sb.push_back(e);
        end
    endtask

    task automatic run_slot(input int s, input exp_t e, input int ncyc);
        ev_t ev;
        for (int c = 0; c < ncyc; c++) begin
            if (c < GAPC) begin
                check("gap", {4'h0, an, seg, dp}, {4'h0, BLANK});
            end else begin
                check("show", {4'h0, an, seg, dp}, {4'h0, e.an, e.seg, e.dp});
                check("ready", {15'h0, ready}, {15'h0, e.rdy});
            end
            if (ev_q.size() > 0 && ev_q[0].slot == s && ev_q[0].cyc == c) begin
                ev = ev_q.pop_front();
                check("ready_at_load", {15'h0, ready}, {15'h0, ev.rdy});
                value = ev.v;
                dp_in = ev.d;
                load  = 1'b1;
            end
            tick();
        end
    endtask

    task automatic check_frame(input int nslots);
        exp_t e;
        for (int s = 0; s < nslots; s++) begin
            if (sb.size() == 0) begin
                check("sb_empty", 16'h1, 16'h0);
                return;
            end
            e = sb.pop_front();
            run_slot(s, e, SLOT);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, {4'h0, an, seg, dp}, {4'h0, BLANK});
        check({tag, "_ready"}, {15'h0, ready}, 16'h1);
    endtask

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset("in_reset");
        end
        rst = 1'b1;

        // Frame 0: zeros; accept 12AF at once, then a 16'hFFFF load while busy.
        push_frame(16'h0000, 4'b0000, 1'b0);
        ev_q.push_back('{0, 0, 16'h12AF, 4'b0100, 1'b1});
        ev_q.push_back('{2, 4, 16'hFFFF, 4'b1111, 1'b0});
        check_frame(4);

        // Frame 1: 12AF; load 0005 on the boundary cycle itself.
        push_frame(16'h12AF, 4'b0100, 1'b1);
        ev_q.push_back('{3, SLOT - 1, 16'h0005, 4'b0000, 1'b1});
        check_frame(4);

        // Frame 2: 0005 still pending, 12AF kept.
        push_frame(16'h12AF, 4'b0100, 1'b0);
        check_frame(4);

        // Frame 3: 0005; load 3333, then reset mid-SHOW of digit 2.
        push_frame(16'h0005, 4'b0000, 1'b0);
        ev_q.push_back('{0, 0, 16'h3333, 4'b0000, 1'b1});
        check_frame(2);
        run_slot(2, sb.pop_front(), GAPC + 3);
        rst = 1'b0;
        #1;
        check_reset("reset_mid");
        tick();
        check_reset("reset_hold");
        sb.delete();
        rst = 1'b1;

        // Two frames of zeros: pending 3333 was discarded by reset.
        push_frame(16'h0000, 4'b0000, 1'b1);
        push_frame(16'h0000, 4'b0000, 1'b1);
        check_frame(4);
        check_frame(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter SLOT_CYCLES, default 50000, meaning clk cycles per digit slot (minimum 4).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning anti-ghost blank cycles at the start of each slot (1..SLOT_CYCLES-2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low (0 = reset).
REQ-006 The block SHALL have port value, input, 4*NUM_DIGITS bits: hex nibbles, where nibble i drives digit i and digit 0 is least significant.
REQ-007 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal point request per digit (1 = lit).
REQ-008 The block SHALL have port load, input, 1 bit: capture request for value and dp_in.
REQ-009 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-010 The block SHALL have port seg, output, 7 bits: segments a..g on bits 0..6, active-low.
REQ-011 The block SHALL have port dp, output, 1 bit: decimal point segment, active-low.
REQ-012 The block SHALL have port an, output, NUM_DIGITS bits: digit enables, active-low, one-hot-low or all-high.

Function
REQ-013 A load SHALL be accepted only on a cycle with load=1 and ready=1; the pending register then captures value/dp_in, and ready drops on the next cycle.
REQ-014 A load presented while ready=0 SHALL be ignored, with no queuing.
REQ-015 Pending data SHALL transfer to the display register in the cycle the scan wraps from digit NUM_DIGITS-1 to digit 0 (frame boundary), and ready SHALL re-rise on that same edge, so no frame shows mixed old and new data.
REQ-016 A load accepted on the exact frame-boundary cycle SHALL be held pending until the next boundary.
REQ-017 The scan FSM SHALL have states GAP and SHOW. GAP lasts GAP_CYCLES cycles with an all-ones and seg/dp all-ones. SHOW lasts SLOT_CYCLES-GAP_CYCLES cycles with an[idx]=0. SHOW then moves to GAP with idx+1, wrapping from NUM_DIGITS-1 to 0.
REQ-018 The slot counter SHALL be $clog2(SLOT_CYCLES) bits wide and count 0..SLOT_CYCLES-1, then wrap to 0.
REQ-019 In SHOW, seg SHALL equal the hex decode of display nibble idx (0-F, standard active-low patterns, e.g. 0 → 7'b1000000, 1 → 7'b1111001, F → 7'b0001110), and dp SHALL equal ~dp_reg[idx].
REQ-020 seg, dp and an SHALL all be registered and change on the same clk edge, so an never enables a digit with the previous digit's pattern.

Reset
REQ-021 While rst=0, the block SHALL hold seg=7'h7F, dp=1, an all ones, ready=1, display and pending registers at 0, idx=0, state GAP, and slot counter 0.
REQ-022 After rst deasserts, scanning SHALL begin with GAP of digit 0; reset mid-frame SHALL discard pending data.

Configuration
REQ-023 With macro SEVEN_SEG_LZB_EN defined, digits above the most significant nonzero nibble SHALL show seg=7'h7F in SHOW while an still cycles normally; digit 0 and lit decimal points SHALL never be blanked.
REQ-024 Without SEVEN_SEG_LZB_EN, every digit SHALL display its nibble, including leading zeros.

Structure
REQ-025 Package seven_seg_pkg SHALL hold SEG_BLANK (7'h7F), the 16-entry active-low hex pattern table, and the scan-state enum {GAP, SHOW}.
REQ-026 The combinational nibble decode SHALL live in sub-module hex7_decode (4-bit in, 7-bit out, using the package table), with one instance inside seven_seg_mux.

Verification (NUM_DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2)
REQ-027 Reset release: hold rst=0 for 3 cycles, then release → seg=7F, an=4'b1111 for 2 cycles, then an=4'b1110 with seg=7'b1000000 for 6 cycles.
REQ-028 Load 16'h12AF with dp_in=4'b0100 → ready=0 until the frame boundary; the next frame shows F, A, 2 (dp=0), 1 on an 1110, 1101, 1011, 0111.
REQ-029 Load during ready=0 with 16'hFFFF → ignored; the display keeps the previously accepted value.
REQ-030 With SEVEN_SEG_LZB_EN, load 16'h0005 → digit0 seg=7'b0010010 and digits 1-3 seg=7F during SHOW; without the macro, digits 1-3 show 7'b1000000.
REQ-031 Assert rst=0 mid-SHOW of digit 2 with a load pending → outputs immediately go to reset values and the pending value is never displayed.
